// File: rtl/key_inverter.sv
// Modular inverse engine: d = e^-1 mod totient using the extended Euclidean
// algorithm with a bit-serial shift-subtract divider; n is forwarded as n_out.
module key_inverter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [23:0] e,
  input  logic [23:0] totient,
  input  logic [23:0] n,
  output logic [23:0] d,
  output logic [23:0] n_out,
  output logic        busy,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CHECK  = 3'd1,
    DIV    = 3'd2,
    UPDATE = 3'd3,
    FIX    = 3'd4,
    FIN    = 3'd5
  } state_t;

  state_t      state_r, state_s;
  logic [23:0] e_r, tot_r;
  logic [23:0] r0_r, r1_r;
  logic [23:0] dvd_r;
  logic [24:0] rem_r;
  logic [25:0] t0_r, t1_r;
  logic [4:0]  cnt_r;
  logic        fix_step_r;
  logic [23:0] d_fix_r;
  logic        err_fix_r;

  logic        accept_s;
  logic [24:0] pr_s;
  logic [24:0] sub_s;
  logic        ge_s;
  logic [25:0] prod_s;
  logic [25:0] d_adj_s;
  logic [23:0] d_commit_s;
  logic        err_commit_s;

  assign accept_s = (state_r == IDLE) && start && !busy;

  // One divider step: shift in the next dividend bit, subtract when it fits
  assign pr_s   = {rem_r[23:0], dvd_r[23]};
  assign sub_s  = pr_s - {1'b0, r1_r};
  assign ge_s   = (pr_s >= {1'b0, r1_r});

  // After DIV, dvd_r holds the quotient; low 26 bits of the product are exact
  assign prod_s  = {2'b00, dvd_r} * t1_r;
  assign d_adj_s = t0_r + {2'b00, tot_r};

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) state_s = CHECK;
        else          state_s = IDLE;
      end
      CHECK: begin
        if ((e_r == 24'd0) || (tot_r < 24'd2)) state_s = FIN;
        else                                   state_s = DIV;
      end
      DIV: begin
        if (cnt_r == 5'd23) state_s = UPDATE;
        else                state_s = DIV;
      end
      UPDATE: begin
        if (rem_r[23:0] != 24'd0) state_s = DIV;
        else                      state_s = FIX;
      end
      FIX: begin
        if (fix_step_r) state_s = FIN;
        else            state_s = FIX;
      end
      FIN:     state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Result committed on entry to FIN: early error or the normalised inverse
  always_comb begin
    d_commit_s   = d_fix_r;
    err_commit_s = err_fix_r;
    if (state_r == CHECK) begin
      d_commit_s   = 24'd0;
      err_commit_s = 1'b1;
    end else begin
      d_commit_s   = d_fix_r;
      err_commit_s = err_fix_r;
    end
  end

  // Euclid datapath: operand capture, divider, remainder/coefficient update, fix-up
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      e_r        <= 24'd0;
      tot_r      <= 24'd0;
      r0_r       <= 24'd0;
      r1_r       <= 24'd0;
      dvd_r      <= 24'd0;
      rem_r      <= 25'd0;
      t0_r       <= 26'd0;
      t1_r       <= 26'd0;
      cnt_r      <= 5'd0;
      fix_step_r <= 1'b0;
      d_fix_r    <= 24'd0;
      err_fix_r  <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            e_r   <= e;
            tot_r <= totient;
          end
        end
        CHECK: begin
          r0_r       <= tot_r;
          r1_r       <= e_r;
          t0_r       <= 26'd0;
          t1_r       <= 26'd1;
          dvd_r      <= tot_r;
          rem_r      <= 25'd0;
          cnt_r      <= 5'd0;
          fix_step_r <= 1'b0;
        end
        DIV: begin
          rem_r <= ge_s ? sub_s : pr_s;
          dvd_r <= {dvd_r[22:0], ge_s};
          cnt_r <= cnt_r + 5'd1;
        end
        UPDATE: begin
          r0_r  <= r1_r;
          r1_r  <= rem_r[23:0];
          t0_r  <= t1_r;
          t1_r  <= t0_r - prod_s;
          dvd_r <= r1_r;
          rem_r <= 25'd0;
          cnt_r <= 5'd0;
        end
        FIX: begin
          fix_step_r <= 1'b1;
          if (r0_r != 24'd1) begin
            d_fix_r   <= 24'd0;
            err_fix_r <= 1'b1;
          end else if (t0_r[25]) begin
            d_fix_r   <= d_adj_s[23:0];
            err_fix_r <= 1'b0;
          end else begin
            d_fix_r   <= t0_r[23:0];
            err_fix_r <= 1'b0;
          end
        end
        default: begin
          fix_step_r <= fix_step_r;
        end
      endcase
    end
  end

  // Registered outputs: status follows the next state, results held until next accept
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      d     <= 24'd0;
      n_out <= 24'd0;
      busy  <= 1'b0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      busy <= (state_s != IDLE);
      done <= (state_s == FIN);
      if (accept_s) begin
        n_out <= n;
      end else begin
        n_out <= n_out;
      end
      if ((state_s == FIN) && (state_r != FIN)) begin
        d   <= d_commit_s;
        err <= err_commit_s;
      end else begin
        d   <= d;
        err <= err;
      end
    end
  end

endmodule

// File: tb/tb_key_inverter.sv
// Directed and randomized checks of key_inverter against an arithmetic
// extended-Euclid reference model.
module tb_key_inverter;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [23:0] e, totient, n;
  logic [23:0] d, n_out;
  logic        busy, done, err;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  key_inverter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .e(e), .totient(totient), .n(n),
    .d(d), .n_out(n_out), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: textbook extended Euclid on plain integers
  task automatic model(input longint ee, input longint tt,
                       output longint dd, output bit er, output int lat);
    longint r0, r1, t0, t1, q, tmp;
    int k;
    if (ee == 0 || tt < 2) begin
      dd = 0; er = 1'b1; lat = 2;
    end else begin
      r0 = tt; r1 = ee; t0 = 0; t1 = 1; k = 0;
      while (r1 != 0) begin
        q = r0 / r1;
        tmp = r0 - q * r1; r0 = r1; r1 = tmp;
        tmp = t0 - q * t1; t0 = t1; t1 = tmp;
        k++;
      end
      if (r0 != 1) begin
        dd = 0; er = 1'b1;
      end else begin
        dd = ((t0 % tt) + tt) % tt; er = 1'b0;
      end
      lat = 25 * k + 4;
    end
  endtask

  // Issue one request from a negedge; returns at the negedge after the done cycle
  task automatic do_req(input logic [23:0] ee, input logic [23:0] tt,
                        input logic [23:0] nn, input bit noisy, input string tag);
    longint exp_d; bit exp_err; int exp_lat;
    int lat; bit busy_ok; int dc0;
    model(ee, tt, exp_d, exp_err, exp_lat);
    start = 1'b1; e = ee; totient = tt; n = nn;
    @(posedge clk);
    dc0 = done_cnt;
    #1;
    if (!noisy) start = 1'b0;
    lat = 0; busy_ok = 1'b1;
    while (done !== 1'b1 && lat < 1000) begin
      @(negedge clk);
      lat++;
      if (busy !== 1'b1) busy_ok = 1'b0;
      if (noisy) begin
        e = 24'($urandom); totient = 24'($urandom); n = 24'($urandom);
      end
    end
    chk({tag, " latency"}, lat, exp_lat);
    chk({tag, " busy"}, busy_ok, 1);
    chk({tag, " d"}, d, exp_d);
    chk({tag, " err"}, err, exp_err);
    chk({tag, " n_out"}, n_out, nn);
    if (!exp_err) chk({tag, " d*e mod tot"}, (longint'(d) * ee) % tt, 1);
    @(negedge clk);
    if (noisy) start = 1'b0;
    chk({tag, " done pulse"}, done, 0);
    chk({tag, " busy low"}, busy, 0);
    chk({tag, " d held"}, d, exp_d);
    chk({tag, " done count"}, done_cnt - dc0, 1);
  endtask

  initial begin
    int dc0;
    rst_n = 1'b0; start = 1'b0; e = 24'd0; totient = 24'd0; n = 24'd0;
    repeat (3) @(negedge clk);
    chk("reset d", d, 0);
    chk("reset n_out", n_out, 0);
    chk("reset busy", busy, 0);
    chk("reset done", done, 0);
    chk("reset err", err, 0);

    // First accept on the first edge with rst_n high
    rst_n = 1'b1;
    do_req(24'd17, 24'd3120, 24'd3233, 1'b0, "rsa17");
    do_req(24'd3, 24'd40, 24'd55, 1'b0, "e3t40");
    do_req(24'd6, 24'd40, 24'd55, 1'b0, "e6t40");
    do_req(24'd0, 24'd3120, 24'd3233, 1'b0, "e0");
    do_req(24'd17, 24'd1, 24'd3233, 1'b0, "tot1");
    do_req(24'd3137, 24'd3120, 24'd3233, 1'b0, "e_ge_tot");
    do_req(24'd17, 24'd3120, 24'd3233, 1'b1, "noisy");

    // Reset in the middle of the divider
    start = 1'b1; e = 24'd17; totient = 24'd3120; n = 24'd3233;
    @(posedge clk);
    #1 start = 1'b0;
    dc0 = done_cnt;
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    chk("midrst busy", busy, 0);
    chk("midrst done", done, 0);
    chk("midrst d", d, 0);
    chk("midrst n_out", n_out, 0);
    chk("midrst err", err, 0);
    rst_n = 1'b1;
    repeat (30) @(negedge clk);
    chk("midrst no done", done_cnt - dc0, 0);
    do_req(24'd17, 24'd3120, 24'd3233, 1'b0, "post_rst");

    // Randomized requests: small and full-width operands
    for (int i = 0; i < 24; i++) begin
      logic [23:0] re, rt;
      if (i % 2 == 0) begin
        rt = 24'($urandom_range(2, 5000));
        re = 24'($urandom_range(1, 6000));
      end else begin
        rt = 24'($urandom);
        re = 24'($urandom);
      end
      do_req(re, rt, 24'($urandom), 1'b0, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/key_inverter.md
KEY_INVERTER -- requirements
Module: key_inverter

Interface
REQ-001 SHALL have ports: clk  input  1  rising-edge clock, sole clock domain.
REQ-002 SHALL have: rst_n  input  1  reset, synchronous, active-low.
REQ-003 SHALL have: start  input  1  request pulse; operands sampled on the cycle start=1 and busy=0.
REQ-004 SHALL have: e  input  24  public exponent from the prime/key source stage.
REQ-005 SHALL have: totient  input  24  (p-1)*(q-1) from the prime/key source stage.
REQ-006 SHALL have: n  input  24  modulus p*q from the prime/key source stage.
REQ-007 SHALL have: d  output  24  private exponent, d*e == 1 mod totient, 0 <= d < totient.
REQ-008 SHALL have: n_out  output  24  copy of n captured at accept, for the downstream decryptor.
REQ-009 SHALL have: busy  output  1  high from the cycle after accept until the done cycle, inclusive.
REQ-010 SHALL have: done  output  1  one-cycle pulse; d, n_out and err are valid from this cycle until the next accept.
REQ-011 SHALL have: err  output  1  valid with done; 1 = no inverse exists, and d=0.

Function
REQ-012 SHALL accept a request only when start=1 and busy=0; start while busy SHALL be ignored and SHALL NOT disturb the computation.
REQ-013 SHALL latch e, totient and n at accept; input changes after accept SHALL NOT affect the result.
REQ-014 SHALL implement the FSM states IDLE, CHECK, DIV, UPDATE, FIX, FIN.
REQ-015 IDLE->CHECK SHALL occur on accept.
REQ-016 In CHECK, if e=0 or totient<2, the block SHALL go to FIN with err=1.
REQ-017 In CHECK otherwise, the block SHALL set r0=totient, r1=e, t0=0, t1=1 and go to DIV.
REQ-018 DIV SHALL compute q=r0/r1 and rem=r0%r1 with a bit-serial shift-subtract divider: exactly 24 cycles, one quotient bit per cycle, MSB first, 25-bit partial remainder.
REQ-019 UPDATE SHALL take 1 cycle: (r0,r1)<=(r1,rem) and (t0,t1)<=(t1,t0-q*t1).
REQ-020 UPDATE SHALL use 26-bit two's-complement t registers with the product truncated to 26 bits; this is exact because |t| <= totient.
REQ-021 After UPDATE, if r1!=0 the block SHALL return to DIV; otherwise it SHALL go to FIX.
REQ-022 e >= totient SHALL need no special case: the first iteration yields q=0 and swaps the operands.
REQ-023 In FIX, if r0!=1 (gcd>1) the block SHALL set err=1 and d=0.
REQ-024 In FIX otherwise, the block SHALL set d=t0 if t0>=0, else d=t0+totient, with the result in [0,totient).
REQ-025 In FIN, done SHALL be 1 for one cycle, busy SHALL fall the next cycle, and the next state SHALL be IDLE.
REQ-026 A new start SHALL be accepted no earlier than the cycle after done.
REQ-027 Latency SHALL be 2 + k*25 + 2 cycles from accept to done, where k = number of Euclid iterations (k<=35 for 24-bit operands, so latency <=879).
REQ-028 The error path from CHECK SHALL produce done 2 cycles after accept.
REQ-029 d, n_out and err SHALL hold their values between done and the next accept.

Reset
REQ-030 With rst_n=0 at a clk edge, the block SHALL enter IDLE and set d=0, n_out=0, busy=0, done=0, err=0, and clear all datapath registers.
REQ-031 Reset SHALL take priority over start and abort any computation in progress with no done pulse.
REQ-032 The first accept SHALL be possible on the first edge with rst_n=1.

Verification
REQ-033 e=17, totient=3120, n=3233, start pulse -> one done pulse, d=2753, err=0, n_out=3233, latency matches REQ-027.
REQ-034 e=3, totient=40 -> d=27, err=0; e=6, totient=40 -> err=1, d=0 (gcd 2).
REQ-035 e=0 or totient=1 -> done exactly 2 cycles after accept, err=1, d=0.
REQ-036 e=3120+17=3137, totient=3120 -> d=2753 (e>=totient path).
REQ-037 start held high and inputs changed throughout a run -> result unchanged, exactly one done, next accept only after done.
REQ-038 rst_n=0 asserted mid-DIV -> busy=0 and all outputs 0 next cycle, no done; a fresh request afterwards computes correctly.
